// File: rtl/softmax_argmax_if.sv
// Handshake and payload bundle between the softmax stage and the argmax back end.
interface softmax_argmax_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDX_WIDTH   = 4
);
  logic                              enable;
  logic [DATA_WIDTH*NUM_CLASSES-1:0] probs;
  logic [IDX_WIDTH-1:0]              class_idx;
  logic [DATA_WIDTH-1:0]             max_prob;
  logic                              all_nan;
  logic                              ack;

  modport master (output enable, probs, input class_idx, max_prob, all_nan, ack);
  modport slave  (input enable, probs, output class_idx, max_prob, all_nan, ack);
endinterface

// File: rtl/softmax_argmax.sv
// Serial argmax over a latched float32 probability vector; reports winning index/value with a level ack.
module softmax_argmax #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  softmax_argmax_if.slave  bus
);
  localparam int unsigned MAN_WIDTH = 23;
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [DATA_WIDTH-1:0] QNAN     = DATA_WIDTH'(32'h7FC0_0000);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] bank [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] best;
  logic [IDX_WIDTH-1:0]  best_idx;
  logic [IDX_WIDTH-1:0]  i;
  logic [IDX_WIDTH-1:0]  class_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic                  nan_q;
  logic                  ack_q;

  logic                  ack_d, load, step, finish, replace;
  logic [DATA_WIDTH-1:0] elem, cand;
  logic [IDX_WIDTH-1:0]  cand_idx;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
    return (&x[DATA_WIDTH-2:MAN_WIDTH]) && (|x[MAN_WIDTH-1:0]);
  endfunction

  // Monotonic unsigned key; -0 is folded onto +0 so the two compare equal.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-2:0] mag;
    mag = x[DATA_WIDTH-2:0];
    if (!x[DATA_WIDTH-1] || mag == '0) return {1'b1, mag};
    return {1'b0, ~mag};
  endfunction

  always_comb begin
    elem     = bank[i];
    replace  = !is_nan(elem) && (is_nan(best) || (order_key(elem) > order_key(best)));
    cand     = replace ? elem : best;
    cand_idx = replace ? i : best_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus datapath strobes; ack holds one cycle even if enable already fell.
  always_comb begin
    state_next = state;
    ack_d      = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          load       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        step = 1'b1;
        if (i == LAST_IDX) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        ack_d = bus.enable || !ack_q;
        if (!bus.enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_CLASSES); k++) bank[k] <= '0;
      best     <= '0;
      best_idx <= '0;
      i        <= '0;
      class_q  <= '0;
      max_q    <= '0;
      nan_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= ack_d;
      if (load) begin
        for (int k = 0; k < int'(NUM_CLASSES); k++)
          bank[k] <= bus.probs[DATA_WIDTH*k +: DATA_WIDTH];
        best     <= bus.probs[DATA_WIDTH-1:0];
        best_idx <= '0;
        i        <= IDX_WIDTH'(1);
      end
      if (step) begin
        best     <= cand;
        best_idx <= cand_idx;
        i        <= i + IDX_WIDTH'(1);
      end
      if (finish) begin
        nan_q   <= is_nan(cand);
        class_q <= is_nan(cand) ? '0 : cand_idx;
        max_q   <= is_nan(cand) ? QNAN : cand;
      end
    end
  end

  assign bus.class_idx = class_q;
  assign bus.max_prob  = max_q;
  assign bus.all_nan   = nan_q;
  assign bus.ack       = ack_q;
endmodule

// File: tb/tb_softmax_argmax.sv
// Directed vector bench for softmax_argmax: table of vectors plus reset/retrigger/enable-drop sequences.
module tb_softmax_argmax;
  localparam int unsigned DW = 32;
  localparam int unsigned NC = 10;
  localparam int unsigned IW = 4;
  localparam int NVEC = 10;

  typedef struct {
    logic [DW*NC-1:0] probs;
    logic [IW-1:0]    idx;
    logic [DW-1:0]    maxv;
    logic             nan;
  } vec_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  vec_t vecs [NVEC];

  softmax_argmax_if #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) bus ();

  softmax_argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW*NC-1:0] fill(input logic [DW-1:0] v);
    logic [DW*NC-1:0] r;
    for (int k = 0; k < int'(NC); k++) r[DW*k +: DW] = v;
    return r;
  endfunction

  function automatic logic [DW*NC-1:0] put(input logic [DW*NC-1:0] r, input int k,
                                            input logic [DW-1:0] v);
    logic [DW*NC-1:0] o;
    o = r;
    o[DW*k +: DW] = v;
    return o;
  endfunction

  // Starts at IDLE with enable low; returns number of ticks after the capture edge until ack.
  task automatic start_and_wait(input logic [DW*NC-1:0] p, output int n);
    bus.probs  = p;
    bus.enable = 1'b1;
    tick();
    n = 0;
    while (!bus.ack && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic run_vec(input int v);
    int n;
    string tag;
    tag = $sformatf("vec%0d", v);
    start_and_wait(vecs[v].probs, n);
    chk({tag, "_latency"}, 32'(n), 32'd10);
    chk({tag, "_idx"}, 32'(bus.class_idx), 32'(vecs[v].idx));
    chk({tag, "_max"}, bus.max_prob, vecs[v].maxv);
    chk({tag, "_nan"}, 32'(bus.all_nan), 32'(vecs[v].nan));
    bus.enable = 1'b0;
    tick();
    chk({tag, "_ack_drop"}, 32'(bus.ack), 32'd0);
    tick();
    chk({tag, "_idx_hold"}, 32'(bus.class_idx), 32'(vecs[v].idx));
  endtask

  initial begin
    int n;
    int hold_bad;
    errors = 0;
    checks = 0;
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.probs  = '0;

    vecs[0] = '{put(fill(32'h3C23D70A), 3, 32'h3F666666), 4'd3, 32'h3F666666, 1'b0};
    vecs[1] = '{put(put(fill(32'h0), 2, 32'h3F000000), 7, 32'h3F000000), 4'd2, 32'h3F000000, 1'b0};
    vecs[2] = '{put(put(fill(32'hBF800000), 0, 32'h80000000), 1, 32'h00000000), 4'd0, 32'h80000000, 1'b0};
    vecs[3] = '{put(put(fill(32'hC0000000), 0, 32'h7FC00000), 5, 32'hBF800000), 4'd5, 32'hBF800000, 1'b0};
    vecs[4] = '{put(fill(32'h7F800001), 4, 32'hFFC00000), 4'd0, 32'h7FC00000, 1'b1};
    vecs[5] = '{put(fill(32'h00000000), 6, 32'h00000001), 4'd6, 32'h00000001, 1'b0};
    vecs[6] = '{put(fill(32'h7F7FFFFF), 9, 32'h7F800000), 4'd9, 32'h7F800000, 1'b0};
    vecs[7] = '{put(fill(32'hFF800000), 8, 32'h7FC00000), 4'd0, 32'hFF800000, 1'b0};
    vecs[8] = '{put(fill(32'hBF800000), 4, 32'hBF000000), 4'd4, 32'hBF000000, 1'b0};
    vecs[9] = '{put(fill(32'h7FC00000), 9, 32'hFF800000), 4'd9, 32'hFF800000, 1'b0};

    tick();
    tick();
    reset = 1'b0;
    chk("reset_ack", 32'(bus.ack), 32'd0);
    chk("reset_idx", 32'(bus.class_idx), 32'd0);
    chk("reset_max", bus.max_prob, 32'd0);
    chk("reset_nan", 32'(bus.all_nan), 32'd0);

    for (int v = 0; v < NVEC; v++) run_vec(v);

    // Reset in the middle of a scan, then a clean rerun.
    bus.probs  = vecs[0].probs;
    bus.enable = 1'b1;
    tick();
    repeat (5) tick();
    reset      = 1'b1;
    bus.enable = 1'b0;
    tick();
    reset = 1'b0;
    chk("midreset_ack", 32'(bus.ack), 32'd0);
    chk("midreset_idx", 32'(bus.class_idx), 32'd0);
    chk("midreset_max", bus.max_prob, 32'd0);
    repeat (3) tick();
    chk("midreset_no_ack", 32'(bus.ack), 32'd0);
    run_vec(0);

    // Inputs change during scan; enable held in DONE.
    bus.probs  = vecs[0].probs;
    bus.enable = 1'b1;
    tick();
    bus.probs = vecs[1].probs;
    n = 0;
    while (!bus.ack && n < 30) begin
      tick();
      n++;
    end
    chk("chg_latency", 32'(n), 32'd10);
    chk("chg_idx", 32'(bus.class_idx), 32'd3);
    chk("chg_max", bus.max_prob, 32'h3F666666);
    hold_bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.ack !== 1'b1 || bus.class_idx !== 4'd3) hold_bad++;
    end
    chk("hold_stable", 32'(hold_bad), 32'd0);
    bus.enable = 1'b0;
    tick();
    chk("hold_ack_drop", 32'(bus.ack), 32'd0);
    tick();

    // Enable dropped mid-scan: scan completes, ack pulses once.
    bus.probs  = vecs[8].probs;
    bus.enable = 1'b1;
    tick();
    repeat (3) tick();
    bus.enable = 1'b0;
    n = 3;
    while (!bus.ack && n < 30) begin
      tick();
      n++;
    end
    chk("drop_latency", 32'(n), 32'd10);
    chk("drop_idx", 32'(bus.class_idx), 32'd4);
    tick();
    chk("drop_pulse_end", 32'(bus.ack), 32'd0);
    hold_bad = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.ack !== 1'b0) hold_bad++;
    end
    chk("drop_no_retrigger", 32'(hold_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
